key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_key_event_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// PS/2 scan-byte parser with event FIFO, modifier tracking and a small voice/volume engine.
// Ports: clk/clrn; data/ready/nextdata_n byte handshake; ev_* FIFO head and pop;
//   ev_overflow/ovf_clr sticky drop flag; shift/ctrl/alt/capslock modifiers;
//   audio_ena gating voice_active/voice_note/volume.
module key_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_VOICES = 4,
  parameter int VOL_MAX    = 80,
  parameter int VOL_INIT   = 77
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic [7:0]                data,
  input  logic                      ready,
  output logic                      nextdata_n,
  output logic                      ev_valid,
  output logic [7:0]                ev_code,
  output logic                      ev_ext,
  output logic                      ev_break,
  output logic                      ev_repeat,
  input  logic                      ev_ready,
  output logic                      ev_overflow,
  input  logic                      ovf_clr,
  output logic                      shift,
  output logic                      ctrl,
  output logic                      alt,
  output logic                      capslock,
  input  logic                      audio_ena,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [3*NUM_VOICES-1:0]   voice_note,
  output logic [6:0]                volume
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [6:0] VMAX  = 7'(VOL_MAX);
  localparam logic [6:0] VINIT = 7'(VOL_INIT);
  localparam logic [2:0] VLAST = 3'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE, GOT_E0, GOT_F0, GOT_E0F0
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ev_t;

  state_t r_state, w_state_n;
  logic r_ack, w_take, w_evt;
  logic w_is_e0, w_is_f0, w_is_drop;
  logic r_pend, r_pext, r_pbrk;
  logic [7:0] r_pcode;
  logic [255:0] r_held_p, r_held_e;
  logic w_rep;
  ev_t w_ev, w_head;
  ev_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_pop, w_full, w_wr, w_drop;
  logic r_ovf, r_caps;
  logic [NUM_VOICES-1:0] r_vact, w_vact_n;
  logic [NUM_VOICES-1:0][2:0] r_vnote, w_vnote_n;
  logic [2:0] r_steal, w_steal_n, w_sel, w_nidx;
  logic [6:0] r_vol, w_vol_n;
  logic w_nhit, w_found, w_free;

  // byte handshake: one consume, then one ack cycle
  assign w_take     = ready & ~r_ack;
  assign nextdata_n = ~r_ack;

  assign w_is_e0   = (data == 8'hE0);
  assign w_is_f0   = (data == 8'hF0);
  assign w_is_drop = (data == 8'h00) | (data == 8'hE1) | (data == 8'hFF);

  always_comb begin
    w_state_n = r_state;
    w_evt     = 1'b0;
    if (w_take) begin
      unique case (1'b1)
        w_is_e0: begin
          if (r_state == IDLE) w_state_n = GOT_E0;
        end
        w_is_f0: begin
          if (r_state == IDLE) w_state_n = GOT_F0;
          else if (r_state == GOT_E0) w_state_n = GOT_E0F0;
        end
        w_is_drop: w_state_n = IDLE;
        default: begin
          w_evt     = 1'b1;
          w_state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ack   <= 1'b0;
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_pcode <= '0;
      r_pext  <= 1'b0;
      r_pbrk  <= 1'b0;
    end else begin
      r_ack   <= w_take;
      r_state <= w_state_n;
      r_pend  <= w_evt;
      if (w_evt) begin
        r_pcode <= data;
        r_pext  <= (r_state == GOT_E0) | (r_state == GOT_E0F0);
        r_pbrk  <= (r_state == GOT_F0) | (r_state == GOT_E0F0);
      end
    end
  end

  assign w_rep = ~r_pbrk & (r_pext ? r_held_e[r_pcode] : r_held_p[r_pcode]);
  assign w_ev  = {r_pcode, r_pext, r_pbrk, w_rep};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_held_p <= '0;
      r_held_e <= '0;
      r_caps   <= 1'b0;
    end else if (r_pend) begin
      if (r_pext) r_held_e[r_pcode] <= ~r_pbrk;
      else        r_held_p[r_pcode] <= ~r_pbrk;
      if (!r_pext && !r_pbrk && !w_rep && r_pcode == 8'h58)
        r_caps <= ~r_caps;
    end
  end

  assign shift    = r_held_p[8'h12] | r_held_p[8'h59];
  assign ctrl     = r_held_p[8'h14] | r_held_e[8'h14];
  assign alt      = r_held_p[8'h11] | r_held_e[8'h11];
  assign capslock = r_caps;

  // FIFO: a pop frees the slot for a same-cycle push when full
  assign w_pop  = (r_cnt != '0) & ev_ready;
  assign w_full = (r_cnt == DEPTH_C);
  assign w_wr   = r_pend & (~w_full | w_pop);
  assign w_drop = r_pend & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= w_ev;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign w_head      = r_mem[r_rp];
  assign ev_valid    = (r_cnt != '0);
  assign ev_code     = w_head.code;
  assign ev_ext      = w_head.ext;
  assign ev_break    = w_head.brk;
  assign ev_repeat   = w_head.rep;
  assign ev_overflow = r_ovf;

  always_comb begin
    w_nhit = 1'b1;
    w_nidx = 3'd0;
    unique case (r_pcode)
      8'h1C: w_nidx = 3'd0;
      8'h1B: w_nidx = 3'd1;
      8'h23: w_nidx = 3'd2;
      8'h2B: w_nidx = 3'd3;
      8'h34: w_nidx = 3'd4;
      8'h33: w_nidx = 3'd5;
      8'h3B: w_nidx = 3'd6;
      8'h42: w_nidx = 3'd7;
      default: w_nhit = 1'b0;
    endcase
  end

  always_comb begin
    w_vact_n  = r_vact;
    w_vnote_n = r_vnote;
    w_steal_n = r_steal;
    w_vol_n   = r_vol;
    w_found   = 1'b0;
    w_free    = 1'b0;
    w_sel     = 3'd0;
    if (!audio_ena) begin
      w_vact_n = '0;
    end else if (r_pend && !r_pext) begin
      if (w_nhit && r_pbrk) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (r_vact[i] && r_vnote[i] == w_nidx) w_vact_n[i] = 1'b0;
      end else if (w_nhit && !w_rep) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (r_vact[i] && r_vnote[i] == w_nidx) w_found = 1'b1;
        // descending scan so the lowest free voice wins
        for (int i = NUM_VOICES - 1; i >= 0; i--)
          if (!r_vact[i]) begin
            w_free = 1'b1;
            w_sel  = 3'(i);
          end
        if (!w_found) begin
          if (!w_free) begin
            w_sel     = r_steal;
            w_steal_n = (r_steal == VLAST) ? 3'd0 : r_steal + 3'd1;
          end
          for (int i = 0; i < NUM_VOICES; i++)
            if (3'(i) == w_sel) begin
              w_vact_n[i]  = 1'b1;
              w_vnote_n[i] = w_nidx;
            end
        end
      end
      if (!r_pbrk && r_pcode == 8'h16 && r_vol < VMAX)
        w_vol_n = r_vol + 7'd1;
      if (!r_pbrk && r_pcode == 8'h1E && r_vol != 7'd0)
        w_vol_n = r_vol - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_vact  <= '0;
      r_vnote <= '0;
      r_steal <= 3'd0;
      r_vol   <= VINIT;
    end else begin
      r_vact  <= w_vact_n;
      r_vnote <= w_vnote_n;
      r_steal <= w_steal_n;
      r_vol   <= w_vol_n;
    end
  end

  assign voice_active = r_vact;
  assign voice_note   = r_vnote;
  assign volume       = r_vol;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: packet table plus
// handshake, FIFO overflow, voice, volume, capslock and reset sequences.
module tb_key_event_decoder;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  data;
  logic        ready;
  logic        nextdata_n;
  logic        ev_valid;
  logic [7:0]  ev_code;
  logic        ev_ext, ev_break, ev_repeat;
  logic        ev_ready;
  logic        ev_overflow;
  logic        ovf_clr;
  logic        shift, ctrl, alt, capslock;
  logic        audio_ena;
  logic [3:0]  voice_active;
  logic [11:0] voice_note;
  logic [6:0]  volume;

  int n_checks = 0;
  int n_err    = 0;

  key_event_decoder dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat),
    .ev_ready(ev_ready), .ev_overflow(ev_overflow), .ovf_clr(ovf_clr),
    .shift(shift), .ctrl(ctrl), .alt(alt), .capslock(capslock),
    .audio_ena(audio_ena), .voice_active(voice_active),
    .voice_note(voice_note), .volume(volume)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0] n;
    logic [7:0] b0, b1, b2;
    logic       ev;
    logic [7:0] code;
    logic       ext, brk, rep;
    logic [2:0] mods;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [1:0] n,
                              input logic [7:0] b0, b1, b2,
                              input logic ev, input logic [7:0] code,
                              input logic e, b, r,
                              input logic [2:0] m);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.ev = ev; v.code = code;
    v.ext = e; v.brk = b; v.rep = r; v.mods = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data  = b;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; data = 8'h00; ready = 1'b0; ev_ready = 1'b0;
    ovf_clr = 1'b0; audio_ena = 1'b0;

    // {shift,ctrl,alt}
    tbl[0]  = mk(1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 3'b000);
    tbl[1]  = mk(2, 8'hF0, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 3'b000);
    tbl[2]  = mk(2, 8'hE0, 8'h14, 0, 1, 8'h14, 1, 0, 0, 3'b010);
    tbl[3]  = mk(3, 8'hE0, 8'hF0, 8'h14, 1, 8'h14, 1, 1, 0, 3'b000);
    tbl[4]  = mk(3, 8'hE0, 8'hE0, 8'h14, 1, 8'h14, 1, 0, 0, 3'b010);
    tbl[5]  = mk(1, 8'h14, 0, 0, 1, 8'h14, 0, 0, 0, 3'b010);
    tbl[6]  = mk(3, 8'hE0, 8'hF0, 8'h14, 1, 8'h14, 1, 1, 0, 3'b010);
    tbl[7]  = mk(2, 8'hF0, 8'h14, 0, 1, 8'h14, 0, 1, 0, 3'b000);
    tbl[8]  = mk(1, 8'h12, 0, 0, 1, 8'h12, 0, 0, 0, 3'b100);
    tbl[9]  = mk(1, 8'h12, 0, 0, 1, 8'h12, 0, 0, 1, 3'b100);
    tbl[10] = mk(2, 8'hF0, 8'h12, 0, 1, 8'h12, 0, 1, 0, 3'b000);
    tbl[11] = mk(2, 8'hE0, 8'h11, 0, 1, 8'h11, 1, 0, 0, 3'b001);
    tbl[12] = mk(3, 8'hF0, 8'hE0, 8'h11, 1, 8'h11, 0, 1, 0, 3'b001);
    tbl[13] = mk(3, 8'hE0, 8'hF0, 8'h11, 1, 8'h11, 1, 1, 0, 3'b000);
    tbl[14] = mk(1, 8'hE1, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
    tbl[15] = mk(3, 8'hF0, 8'h00, 8'h59, 1, 8'h59, 0, 0, 0, 3'b100);
    tbl[16] = mk(3, 8'hF0, 8'hF0, 8'h59, 1, 8'h59, 0, 1, 0, 3'b000);
    tbl[17] = mk(1, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
    tbl[18] = mk(3, 8'hE0, 8'hFF, 8'h1C, 1, 8'h1C, 0, 0, 0, 3'b000);
    tbl[19] = mk(2, 8'hF0, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 3'b000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst nextdata_n", nextdata_n, 1);
    chk("rst ev_valid", ev_valid, 0);
    chk("rst ev_overflow", ev_overflow, 0);
    chk("rst mods", {shift, ctrl, alt, capslock}, 0);
    chk("rst voice_active", voice_active, 0);
    chk("rst voice_note", voice_note, 0);
    chk("rst volume", volume, 77);
    clrn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      send(tbl[i].b0);
      if (tbl[i].n > 1) send(tbl[i].b1);
      if (tbl[i].n > 2) send(tbl[i].b2);
      chk($sformatf("vec%0d ev_valid", i), ev_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d event", i),
            {ev_code, ev_ext, ev_break, ev_repeat},
            {tbl[i].code, tbl[i].ext, tbl[i].brk, tbl[i].rep});
        pop();
      end
      chk($sformatf("vec%0d mods", i), {shift, ctrl, alt}, tbl[i].mods);
    end

    // held ready across the ack cycle must yield exactly one byte
    audio_ena = 1'b1;
    data = 8'h1C; ready = 1'b1;
    @(posedge clk); #1;
    chk("ack low", nextdata_n, 0);
    @(posedge clk); #1;
    ready = 1'b0;
    chk("ack high", nextdata_n, 1);
    chk("make 1C event", {ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
        {1'b1, 8'h1C, 3'b000});
    chk("make 1C voice", {voice_active, voice_note[2:0]}, {4'b0001, 3'd0});
    pop();
    chk("single event", ev_valid, 0);
    send(8'hF0); send(8'h1C);
    chk("break 1C event", {ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
        {1'b1, 8'h1C, 3'b010});
    chk("break 1C voice", voice_active, 0);
    pop();

    // FIFO fill, simultaneous push/pop when full, drop with clear
    audio_ena = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h2B);
    chk("full no ovf", ev_overflow, 0);
    chk("full head", {ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
        {1'b1, 8'h2B, 3'b000});
    data = 8'h2B; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
    chk("push+pop full ovf", ev_overflow, 0);
    ovf_clr = 1'b1;
    send(8'h2B);
    ovf_clr = 1'b0;
    chk("drop with clr ovf", ev_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i),
          {ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
          {1'b1, 8'h2B, 3'b001});
      pop();
    end
    chk("drained", ev_valid, 0);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf cleared", ev_overflow, 0);
    send(8'hF0); send(8'h2B); pop();

    // voice allocation and stealing
    audio_ena = 1'b1; ev_ready = 1'b1;
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("4 voices", {voice_active, voice_note},
        {4'b1111, 3'd3, 3'd2, 3'd1, 3'd0});
    send(8'h34);
    chk("steal v0", {voice_active, voice_note},
        {4'b1111, 3'd3, 3'd2, 3'd1, 3'd4});
    send(8'h33);
    chk("steal v1", voice_note, {3'd3, 3'd2, 3'd5, 3'd4});
    send(8'h23);
    chk("repeat no alloc", {voice_active, voice_note},
        {4'b1111, 3'd3, 3'd2, 3'd5, 3'd4});
    send(8'hF0); send(8'h2B);
    chk("break frees v3", {voice_active, voice_note},
        {4'b0111, 3'd3, 3'd2, 3'd5, 3'd4});
    send(8'h42);
    chk("lowest free", {voice_active, voice_note},
        {4'b1111, 3'd7, 3'd2, 3'd5, 3'd4});
    audio_ena = 1'b0;
    @(posedge clk); #1;
    chk("audio off clears", {voice_active, voice_note},
        {4'b0000, 3'd7, 3'd2, 3'd5, 3'd4});
    ev_ready = 1'b0;
    send(8'h3B);
    chk("audio off queued", {ev_valid, ev_code}, {1'b1, 8'h3B});
    chk("audio off no voice", voice_active, 0);
    pop();
    audio_ena = 1'b1; ev_ready = 1'b1;

    // volume saturation
    send(8'h16); send(8'h16);
    chk("vol 79", volume, 79);
    for (int i = 0; i < 3; i++) begin
      send(8'h16);
      chk($sformatf("vol sat%0d", i), volume, 80);
    end
    for (int i = 0; i < 80; i++) send(8'h1E);
    chk("vol down 0", volume, 0);
    send(8'h1E);
    chk("vol floor", volume, 0);

    // capslock toggling
    send(8'h58);
    chk("caps make", capslock, 1);
    send(8'h58);
    chk("caps repeat", capslock, 1);
    send(8'hF0); send(8'h58);
    chk("caps break", capslock, 1);
    send(8'hE0); send(8'h58);
    chk("caps ext make", capslock, 1);
    send(8'h58);
    chk("caps toggle back", capslock, 0);

    // reset in the middle of a packet
    send(8'hF0); send(8'h3B); send(8'h3B);
    chk("pre-reset voice", |voice_active, 1);
    ev_ready = 1'b0;
    send(8'hE0); send(8'hF0);
    clrn = 1'b0;
    #2;
    chk("mid rst ifc", {nextdata_n, ev_valid, ev_overflow}, 3'b100);
    chk("mid rst mods", {shift, ctrl, alt, capslock}, 0);
    chk("mid rst voice", {voice_active, voice_note}, 0);
    chk("mid rst volume", volume, 77);
    #2;
    clrn = 1'b1;
    @(posedge clk); #1;
    send(8'h1C);
    chk("post rst event", {ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
        {1'b1, 8'h1C, 3'b000});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
